// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule sequencer: drives one shared round-key generator
// for NR rounds and keeps round keys 0..NR in a key store with a registered read port.
module aes_key_sched_ctrl #(
    parameter int unsigned NR      = 10,
    parameter int unsigned KEY_W   = 128,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] cipher_key,
    output logic             gen_valid_in,
    output logic [31:0]      gen_rcon,
    output logic [KEY_W-1:0] gen_key_in,
    input  logic             gen_valid_out,
    input  logic [KEY_W-1:0] gen_key_out,
    input  logic [3:0]       rd_addr,
    output logic [KEY_W-1:0] rd_key,
    output logic             keys_ready,
    output logic             busy,
    output logic             err
);

    localparam int unsigned RND_W  = 4;
    localparam int unsigned WDOG_W = 4;
    localparam int unsigned RCON_W = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [RND_W-1:0]    round;
    logic [RCON_W-1:0]   rcon8;
    logic [WDOG_W-1:0]   wdog;
    logic [KEY_W-1:0]    slot [0:NR];
    logic                accept;
    logic                last_round;
    logic                wdog_expired;

    assign accept       = key_valid && key_ready;
    assign last_round   = (round == RND_W'(NR));
    assign wdog_expired = (wdog == WDOG_W'(TIMEOUT));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (accept) state_nxt = S_ISSUE;
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (gen_valid_out) begin
                    state_nxt = last_round ? S_DONE : S_ISSUE;
                end else if (wdog_expired) begin
                    state_nxt = S_ERROR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode; generator operands are held for the whole ISSUE/WAIT span
    always_comb begin
        key_ready    = 1'b0;
        gen_valid_in = 1'b0;
        gen_rcon     = '0;
        gen_key_in   = '0;
        keys_ready   = 1'b0;
        busy         = 1'b0;
        err          = 1'b0;
        case (state)
            S_IDLE:  key_ready = 1'b1;
            S_ISSUE: begin
                gen_valid_in = 1'b1;
                busy         = 1'b1;
                gen_rcon     = {rcon8, 24'h0};
                gen_key_in   = slot[round - RND_W'(1)];
            end
            S_WAIT: begin
                busy       = 1'b1;
                gen_rcon   = {rcon8, 24'h0};
                gen_key_in = slot[round - RND_W'(1)];
            end
            S_DONE: begin
                key_ready  = 1'b1;
                keys_ready = 1'b1;
            end
            S_ERROR: begin
                key_ready = 1'b1;
                err       = 1'b1;
            end
            default: ;
        endcase
    end

    // Round counter, RCON, watchdog, key store and read port
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round  <= '0;
            rcon8  <= RCON_W'(8'h01);
            wdog   <= '0;
            rd_key <= '0;
            for (int unsigned i = 0; i <= NR; i++) begin
                slot[i] <= '0;
            end
        end else begin
            rd_key <= (rd_addr <= RND_W'(NR)) ? slot[rd_addr] : '0;
            if (accept) begin
                slot[0] <= cipher_key;
                round   <= RND_W'(1);
                rcon8   <= RCON_W'(8'h01);
            end
            if (state == S_ISSUE) begin
                wdog <= '0;
            end
            if (state == S_WAIT) begin
                if (gen_valid_out) begin
                    slot[round] <= gen_key_out;
                    rcon8       <= {rcon8[6:0], 1'b0} ^ (rcon8[7] ? RCON_W'(8'h1b) : RCON_W'(8'h00));
                    if (!last_round) round <= round + RND_W'(1);
                end else begin
                    wdog <= wdog + WDOG_W'(1);
                end
            end
        end
    end

endmodule
